// File: rtl/probe_freq_counter_if.sv
// Frequency-result handshake between the probe front end (master) and the CPU (slave).
interface probe_freq_counter_if #(
  parameter int COUNT_BITS = 32
);
  logic                  freq_ack;
  logic [COUNT_BITS-1:0] freq_count;
  logic [COUNT_BITS-1:0] high_count;
  logic                  freq_valid;
  logic                  overrun;

  modport master (
    output freq_count, high_count, freq_valid, overrun,
    input  freq_ack
  );

  modport slave (
    input  freq_count, high_count, freq_valid, overrun,
    output freq_ack
  );
endinterface

// File: rtl/probe_freq_counter.sv
// probe_freq_counter: comparator synchroniser, level/pulse LEDs and gated edge counter
// for the vf_meter logic probe. Optional duty-cycle counter built when PROBE_DUTY_EN
// is defined; otherwise high_count is tied to 0.
module probe_freq_counter #(
  parameter int CLK_FREQUENCY_DIV4 = 800000,
  parameter int COUNT_BITS         = 32,
  parameter int LED_STRETCH_BITS   = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 comp_data_hi,
  input  logic                 comp_data_lo,
  probe_freq_counter_if.master freq_bus,
  output logic                 led_one,
  output logic                 led_zero,
  output logic                 led_floating,
  output logic                 led_pulse
);

  localparam int WINDOW    = 4 * CLK_FREQUENCY_DIV4;
  localparam int GATE_BITS = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [GATE_BITS-1:0] GATE_LAST = GATE_BITS'(WINDOW - 1);

  logic                        hi_meta, hi_s, hi_d;
  logic                        lo_meta, lo_s, lo_d;
  logic [LED_STRETCH_BITS-1:0] stretch;
  logic [GATE_BITS-1:0]        gate_cnt;
  logic [COUNT_BITS-1:0]       edge_cnt;
  logic [COUNT_BITS-1:0]       edge_total;
  logic [COUNT_BITS-1:0]       freq_reg;
  logic                        valid_reg;
  logic                        overrun_reg;
  logic                        close;
  logic                        edge_hit;
  logic                        level_change;

  assign close        = (gate_cnt == GATE_LAST);
  assign edge_hit     = hi_s & ~hi_d;
  assign level_change = (hi_s ^ hi_d) | (lo_s ^ lo_d);
  // An edge seen on the closing cycle still belongs to the closing window.
  assign edge_total   = (edge_hit && (edge_cnt != '1)) ? edge_cnt + COUNT_BITS'(1) : edge_cnt;

  assign led_pulse           = (stretch != '0);
  assign freq_bus.freq_count = freq_reg;
  assign freq_bus.freq_valid = valid_reg;
  assign freq_bus.overrun    = overrun_reg;

  // Two-flop synchronisers plus one-cycle delayed copies for edge/change detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_meta <= 1'b0;
      hi_s    <= 1'b0;
      hi_d    <= 1'b0;
      lo_meta <= 1'b0;
      lo_s    <= 1'b0;
      lo_d    <= 1'b0;
    end else begin
      hi_meta <= comp_data_hi;
      hi_s    <= hi_meta;
      hi_d    <= hi_s;
      lo_meta <= comp_data_lo;
      lo_s    <= lo_meta;
      lo_d    <= lo_s;
    end
  end

  // Registered level classification; the illegal hi=lo=1 case reads as floating.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_one      <= 1'b0;
      led_zero     <= 1'b0;
      led_floating <= 1'b0;
    end else begin
      led_one      <= hi_s & ~lo_s;
      led_zero     <= lo_s & ~hi_s;
      led_floating <= ~((hi_s & ~lo_s) | (lo_s & ~hi_s));
    end
  end

  // Activity stretcher: reload on any level change, otherwise count down to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      stretch <= '0;
    end else if (level_change) begin
      stretch <= '1;
    end else if (stretch != '0) begin
      stretch <= stretch - LED_STRETCH_BITS'(1);
    end
  end

  // Gate window counter, wraps after the terminal cycle.
  always_ff @(posedge clk) begin
    if (reset || close) begin
      gate_cnt <= '0;
    end else begin
      gate_cnt <= gate_cnt + GATE_BITS'(1);
    end
  end

  // Saturating edge accumulator, restarted at every window close.
  always_ff @(posedge clk) begin
    if (reset || close) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_total;
    end
  end

  // Result latch and CPU handshake; a close outranks a coincident ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      freq_reg    <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else if (close) begin
      freq_reg    <= edge_total;
      valid_reg   <= 1'b1;
      overrun_reg <= overrun_reg | valid_reg;
    end else if (freq_bus.freq_ack && valid_reg) begin
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end
  end

`ifdef PROBE_DUTY_EN
  logic [COUNT_BITS-1:0] high_acc;
  logic [COUNT_BITS-1:0] high_total;
  logic [COUNT_BITS-1:0] high_reg;

  assign high_total          = (hi_s && (high_acc != '1)) ? high_acc + COUNT_BITS'(1) : high_acc;
  assign freq_bus.high_count = high_reg;

  // Saturating count of hi_s cycles per window, latched alongside freq_count.
  always_ff @(posedge clk) begin
    if (reset) begin
      high_acc <= '0;
      high_reg <= '0;
    end else if (close) begin
      high_acc <= '0;
      high_reg <= high_total;
    end else begin
      high_acc <= high_total;
    end
  end
`else
  assign freq_bus.high_count = '0;
`endif

endmodule

// File: tb/tb_probe_freq_counter.sv
// Directed bench for probe_freq_counter: 100-cycle window, 4-bit stretcher, plus a
// 3-bit-counter copy to exercise saturation.
`timescale 1ns/1ps
module tb_probe_freq_counter;

`ifdef PROBE_DUTY_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic comp_hi = 1'b0;
  logic comp_lo = 1'b0;
  logic ack = 1'b0;
  logic led_one, led_zero, led_floating, led_pulse;
  logic s_one, s_zero, s_float, s_pulse;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit sq_en = 1'b0;
  int sq_per = 10;
  int sq_high = 3;
  int sq_phase = 0;

  always #5 clk = ~clk;

  probe_freq_counter_if #(.COUNT_BITS(32)) bus ();
  probe_freq_counter_if #(.COUNT_BITS(3))  bus_s ();

  assign bus.freq_ack   = ack;
  assign bus_s.freq_ack = ack;

  probe_freq_counter #(
    .CLK_FREQUENCY_DIV4(25), .COUNT_BITS(32), .LED_STRETCH_BITS(4)
  ) dut (
    .clk(clk), .reset(reset), .comp_data_hi(comp_hi), .comp_data_lo(comp_lo),
    .freq_bus(bus.master), .led_one(led_one), .led_zero(led_zero),
    .led_floating(led_floating), .led_pulse(led_pulse)
  );

  probe_freq_counter #(
    .CLK_FREQUENCY_DIV4(25), .COUNT_BITS(3), .LED_STRETCH_BITS(4)
  ) dut_s (
    .clk(clk), .reset(reset), .comp_data_hi(comp_hi), .comp_data_lo(comp_lo),
    .freq_bus(bus_s.master), .led_one(s_one), .led_zero(s_zero),
    .led_floating(s_float), .led_pulse(s_pulse)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // One step = drive inputs at a falling edge, then pass one rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      if (sq_en) begin
        comp_hi  = (sq_phase < sq_high);
        sq_phase = (sq_phase == sq_per - 1) ? 0 : sq_phase + 1;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic to_cyc(input int target);
    if (target > cyc) step(target - cyc);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    step(n);
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    step(1);
    ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    do_reset(2);
    check_val("rst_led_one", led_one, 0);
    check_val("rst_led_zero", led_zero, 0);
    check_val("rst_led_floating", led_floating, 0);
    check_val("rst_led_pulse", led_pulse, 0);
    check_val("rst_valid", bus.freq_valid, 0);
    check_val("rst_overrun", bus.overrun, 0);
    check_val("rst_freq", bus.freq_count, 0);
    check_val("rst_high", bus.high_count, 0);
    check_val("rst_small_leds", {s_one, s_zero, s_float, s_pulse, bus_s.freq_valid}, 0);

    // Level latency: hi=1, lo=0 -> led_one on the third edge.
    comp_hi = 1'b1;
    step(2);
    check_val("one_lat2", led_one, 0);
    step(1);
    check_val("one_lat3", led_one, 1);
    check_val("one_float", led_floating, 0);
    comp_hi = 1'b0; comp_lo = 1'b1;
    step(2);
    check_val("zero_lat2", led_zero, 0);
    step(1);
    check_val("zero_lat3", led_zero, 1);
    check_val("zero_one_off", led_one, 0);

    // Floating latency and the 15-cycle pulse stretch.
    comp_lo = 1'b0;
    step(2);
    check_val("float_lat2", led_floating, 0);
    step(1);
    check_val("float_lat3", led_floating, 1);
    check_val("pulse_reload", led_pulse, 1);
    step(14);
    check_val("pulse_14", led_pulse, 1);
    step(1);
    check_val("pulse_15", led_pulse, 0);

    // Illegal hi=lo=1 reads as floating.
    comp_hi = 1'b1; comp_lo = 1'b1;
    step(3);
    check_val("illegal_float", led_floating, 1);
    check_val("illegal_one", led_one, 0);
    check_val("illegal_zero", led_zero, 0);
    comp_hi = 1'b0; comp_lo = 1'b0;

    // First window saw two hi rising edges; second window is steady 0.
    to_cyc(99);
    check_val("win1_not_yet", bus.freq_valid, 0);
    step(1);
    check_val("win1_valid", bus.freq_valid, 1);
    check_val("win1_freq", bus.freq_count, 2);
    check_val("win1_small_freq", bus_s.freq_count, 2);
    to_cyc(199);
    check_val("win2_no_overrun_yet", bus.overrun, 0);
    step(1);
    check_val("win2_freq_zero", bus.freq_count, 0);
    check_val("win2_valid", bus.freq_valid, 1);
    check_val("win2_overrun", bus.overrun, 1);
    pulse_ack();
    check_val("ack_valid", bus.freq_valid, 0);
    check_val("ack_overrun", bus.overrun, 0);
    pulse_ack();
    check_val("idle_ack_valid", bus.freq_valid, 0);
    check_val("idle_ack_overrun", bus.overrun, 0);

    // Ack coinciding with a close: the close wins.
    to_cyc(300);
    check_val("win3_valid", bus.freq_valid, 1);
    check_val("win3_overrun", bus.overrun, 0);
    to_cyc(399);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check_val("ackclose_valid", bus.freq_valid, 1);
    check_val("ackclose_overrun", bus.overrun, 1);
    pulse_ack();
    check_val("ack2_valid", bus.freq_valid, 0);
    check_val("ack2_overrun", bus.overrun, 0);

    // Reset at window cycle 50 discards the partial count.
    sq_en = 1'b1; sq_per = 10; sq_high = 3; sq_phase = 0;
    to_cyc(450);
    sq_en = 1'b0; comp_hi = 1'b1; comp_lo = 1'b0;
    do_reset(1);
    check_val("mid_rst_leds", {led_one, led_zero, led_floating, led_pulse}, 0);
    check_val("mid_rst_valid", bus.freq_valid, 0);
    check_val("mid_rst_freq", bus.freq_count, 0);
    check_val("mid_rst_high", bus.high_count, 0);
    to_cyc(99);
    check_val("mid_rst_no_close", bus.freq_valid, 0);
    step(1);
    check_val("mid_rst_close", bus.freq_valid, 1);
    check_val("mid_rst_freq1", bus.freq_count, 1);
    check_val("mid_rst_high98", bus.high_count, DUTY ? 98 : 0);
    check_val("mid_rst_small_high", bus_s.high_count, DUTY ? 7 : 0);
    check_val("mid_rst_led_one", led_one, 1);
    pulse_ack();

    // Square wave, period 10, 3 high.
    sq_en = 1'b1; sq_per = 10; sq_high = 3; sq_phase = 0;
    to_cyc(300);
    check_val("sq10_freq", bus.freq_count, 10);
    check_val("sq10_valid", bus.freq_valid, 1);
    check_val("sq10_overrun", bus.overrun, 1);
    check_val("sq10_pulse", led_pulse, 1);
    check_val("sq10_high", bus.high_count, DUTY ? 30 : 0);
    check_val("sq10_small_sat", bus_s.freq_count, 7);

    // Square wave, period 4, 2 high.
    sq_per = 4; sq_high = 2; sq_phase = 0;
    to_cyc(500);
    check_val("sq4_freq", bus.freq_count, 25);
    check_val("sq4_high", bus.high_count, DUTY ? 50 : 0);
    check_val("sq4_small_sat", bus_s.freq_count, 7);
    check_val("sq4_small_high", bus_s.high_count, DUTY ? 7 : 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
